// File: rtl/calc1_pkg.sv
// calc1_pkg: command/response encodings, port FSM state encoding and
// command classification helpers shared by the calc1 unit arbiter.
package calc1_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned ID_W      = 2;

  // Command encodings
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  // Response encodings
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_SUCC = 2'd1;
  localparam logic [1:0] RESP_INOF = 2'd2;
  localparam logic [1:0] RESP_IERR = 2'd3;

  // Port FSM states
  typedef logic [1:0] port_state_t;
  localparam port_state_t ST_IDLE   = 2'd0;
  localparam port_state_t ST_WAIT_A = 2'd1;
  localparam port_state_t ST_WAIT_S = 2'd2;

  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd == CMD_LSH) || (cmd == CMD_RSH);
  endfunction

endpackage

// File: rtl/calc1_port_fifo.sv
// calc1_port_fifo: FIFO of port IDs with up to NPush ordered pushes and one
// pop per cycle. Entry 0 is always the head; a pop shifts the array down and
// pushes land behind the surviving entries, so a same-cycle push is never
// visible at the head before the next edge.
module calc1_port_fifo
  import calc1_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned NPush = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic                       c_clk,
  input  logic                       reset,
  input  logic [NPush-1:0]           push_vld,
  input  logic [NPush-1:0][ID_W-1:0] push_id,
  input  logic                       pop,
  output logic [ID_W-1:0]            head,
  output logic [CntW-1:0]            cnt
);

  logic [ID_W-1:0] mem_q [Depth];
  logic [ID_W-1:0] mem_d [Depth];
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] wr_ptr;

  // Apply the pop first, then append pushes in slot order behind the survivors.
  always_comb begin
    mem_d  = mem_q;
    wr_ptr = cnt_q;
    if (pop && (cnt_q != '0)) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[Depth-1] = '0;
      wr_ptr = cnt_q - CntW'(1);
    end
    for (int i = 0; i < int'(NPush); i++) begin
      if (push_vld[i] && (wr_ptr < CntW'(Depth))) begin
        mem_d[wr_ptr[IdxW-1:0]] = push_id[i];
        wr_ptr = wr_ptr + CntW'(1);
      end
    end
    cnt_d = wr_ptr;
  end

  // Storage and occupancy registers.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head = mem_q[0];
  assign cnt  = cnt_q;

endmodule

// File: rtl/calc1_unit_arbiter.sv
// calc1_unit_arbiter: shares the arithmetic and shift units between four
// request ports. Each port runs an IDLE/WAIT_A/WAIT_S FSM; accepted requests
// are queued per unit in arrival order and one grant per unit is issued per
// cycle. All outputs are registered.
// Build option: define CALC1_ARB_ROTATE_EN to order simultaneous arrivals
// starting after the port last granted by that unit (default: port 1 first).
module calc1_unit_arbiter
  import calc1_pkg::*;
#(
  parameter int unsigned NPORTS = NUM_PORTS,
  parameter int unsigned QDEPTH = NPORTS
) (
  input  logic                  c_clk,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req_vld,
  input  logic [4*NPORTS-1:0]   req_cmd,
  output logic [NPORTS-1:0]     grant_arith,
  output logic [NPORTS-1:0]     grant_shift,
  output logic [NPORTS-1:0]     rej_vld,
  output logic [2*NPORTS-1:0]   rej_code,
  output logic [2:0]            arith_cnt,
  output logic [2:0]            shift_cnt
);

  port_state_t state_q [NPORTS];
  port_state_t state_d [NPORTS];

  logic [NPORTS-1:0]   arith_req;
  logic [NPORTS-1:0]   shift_req;
  logic [NPORTS-1:0]   rej_vld_d;
  logic [NPORTS-1:0]   rej_vld_q;
  logic [2*NPORTS-1:0] rej_code_d;
  logic [2*NPORTS-1:0] rej_code_q;
  logic [NPORTS-1:0]   grant_arith_d;
  logic [NPORTS-1:0]   grant_arith_q;
  logic [NPORTS-1:0]   grant_shift_d;
  logic [NPORTS-1:0]   grant_shift_q;

  logic [ID_W-1:0] arith_head;
  logic [ID_W-1:0] shift_head;
  logic [ID_W-1:0] arith_start;
  logic [ID_W-1:0] shift_start;
  logic [ID_W-1:0] arith_idx;
  logic [ID_W-1:0] shift_idx;
  logic [ID_W-1:0] arith_slot;
  logic [ID_W-1:0] shift_slot;

  logic [NPORTS-1:0]           arith_push_vld;
  logic [NPORTS-1:0]           shift_push_vld;
  logic [NPORTS-1:0][ID_W-1:0] arith_push_id;
  logic [NPORTS-1:0][ID_W-1:0] shift_push_id;

  logic arith_pop;
  logic shift_pop;

  // A non-empty queue always issues its head this edge.
  assign arith_pop = (arith_cnt != '0);
  assign shift_pop = (shift_cnt != '0);

  // Decode the queue heads into one-hot grants for the coming cycle.
  always_comb begin
    grant_arith_d = '0;
    grant_shift_d = '0;
    if (arith_pop) grant_arith_d[arith_head] = 1'b1;
    if (shift_pop) grant_shift_d[shift_head] = 1'b1;
  end

  // Per-port FSM: classify strobes, raise rejects, return to IDLE on grant.
  always_comb begin
    arith_req  = '0;
    shift_req  = '0;
    rej_vld_d  = '0;
    rej_code_d = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      state_d[p] = state_q[p];
      if (req_vld[p]) begin
        if (state_q[p] == ST_IDLE) begin
          if (is_arith(req_cmd[4*p +: 4])) begin
            arith_req[p] = 1'b1;
            state_d[p]   = ST_WAIT_A;
          end else if (is_shift(req_cmd[4*p +: 4])) begin
            shift_req[p] = 1'b1;
            state_d[p]   = ST_WAIT_S;
          end else if (req_cmd[4*p +: 4] != CMD_NOP) begin
            rej_vld_d[p]         = 1'b1;
            rej_code_d[2*p +: 2] = RESP_INOF;
          end
        end else begin
          // Second strobe while a request is outstanding; the pending one stands.
          rej_vld_d[p]         = 1'b1;
          rej_code_d[2*p +: 2] = RESP_IERR;
        end
      end
      if (grant_arith_d[p] || grant_shift_d[p]) state_d[p] = ST_IDLE;
    end
  end

  // Pack simultaneous arrivals into ordered push slots, starting at *_start.
  always_comb begin
    arith_push_vld = '0;
    arith_push_id  = '0;
    shift_push_vld = '0;
    shift_push_id  = '0;
    arith_slot     = '0;
    shift_slot     = '0;
    arith_idx      = '0;
    shift_idx      = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      arith_idx = arith_start + ID_W'(i);
      shift_idx = shift_start + ID_W'(i);
      if (arith_req[arith_idx]) begin
        arith_push_vld[arith_slot] = 1'b1;
        arith_push_id[arith_slot]  = arith_idx;
        arith_slot                 = arith_slot + ID_W'(1);
      end
      if (shift_req[shift_idx]) begin
        shift_push_vld[shift_slot] = 1'b1;
        shift_push_id[shift_slot]  = shift_idx;
        shift_slot                 = shift_slot + ID_W'(1);
      end
    end
  end

`ifdef CALC1_ARB_ROTATE_EN
  logic [ID_W-1:0] arith_last_q;
  logic [ID_W-1:0] shift_last_q;

  // Track the last port each unit served; reset to port 4 so port 1 leads.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      arith_last_q <= ID_W'(NPORTS - 1);
      shift_last_q <= ID_W'(NPORTS - 1);
    end else begin
      if (arith_pop) arith_last_q <= arith_head;
      if (shift_pop) shift_last_q <= shift_head;
    end
  end

  assign arith_start = arith_last_q + ID_W'(1);
  assign shift_start = shift_last_q + ID_W'(1);
`else
  assign arith_start = '0;
  assign shift_start = '0;
`endif

  calc1_port_fifo #(
    .Depth (QDEPTH),
    .NPush (NPORTS)
  ) u_arith_fifo (
    .c_clk    (c_clk),
    .reset    (reset),
    .push_vld (arith_push_vld),
    .push_id  (arith_push_id),
    .pop      (arith_pop),
    .head     (arith_head),
    .cnt      (arith_cnt)
  );

  calc1_port_fifo #(
    .Depth (QDEPTH),
    .NPush (NPORTS)
  ) u_shift_fifo (
    .c_clk    (c_clk),
    .reset    (reset),
    .push_vld (shift_push_vld),
    .push_id  (shift_push_id),
    .pop      (shift_pop),
    .head     (shift_head),
    .cnt      (shift_cnt)
  );

  // Port FSM state and registered grant/reject outputs.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        state_q[p] <= ST_IDLE;
      end
      grant_arith_q <= '0;
      grant_shift_q <= '0;
      rej_vld_q     <= '0;
      rej_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_arith_q <= grant_arith_d;
      grant_shift_q <= grant_shift_d;
      rej_vld_q     <= rej_vld_d;
      rej_code_q    <= rej_code_d;
    end
  end

  assign grant_arith = grant_arith_q;
  assign grant_shift = grant_shift_q;
  assign rej_vld     = rej_vld_q;
  assign rej_code    = rej_code_q;

endmodule

// File: doc/calc1_unit_arbiter.md
# calc1_unit_arbiter

Scheduler that shares the single arithmetic unit (ADD/SUB) and the single shift unit (LSH/RSH) of the calc1 datapath between its four request ports. Each port issues one command strobe and then waits; the arbiter queues it per unit in arrival order and issues one grant per unit per cycle. It sits between the per-port command front-ends and the two shared execution units.

## Interface
- NPORTS, 4, number of request ports; fixed at 4, any other value is unsupported.
- QDEPTH, NPORTS, entries per unit queue; one outstanding request per port means no overflow is possible.
- c_clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- req_vld  in  4  per-port single-cycle command strobe; bit 0 is port 1.
- req_cmd  in  16  4-bit command per port; bits [4p:4p+3] belong to port p+1.
- grant_arith  out  4  one-hot, single-cycle grant of the arithmetic unit.
- grant_shift  out  4  one-hot, single-cycle grant of the shift unit.
- rej_vld  out  4  per-port single-cycle reject pulse.
- rej_code  out  8  2-bit response per port: 2 = invalid command, 3 = protocol error; 0 when rej_vld is low.
- arith_cnt  out  3  current arithmetic queue occupancy, 0..4.
- shift_cnt  out  3  current shift queue occupancy, 0..4.

## Operation
- Each port has a 3-state FSM: IDLE, WAIT_A, WAIT_S.
- IDLE with req_vld=1:
  - cmd 1 or 2: enqueue to the arithmetic queue, go to WAIT_A.
  - cmd 5 or 6: enqueue to the shift queue, go to WAIT_S.
  - cmd 0 with req_vld=1: ignored.
  - any other cmd: rej_vld=1, rej_code=2; the FSM stays IDLE.
- WAIT_A or WAIT_S with req_vld=1: rej_vld=1, rej_code=3; the pending request is unaffected.
- Queues are FIFOs of 2-bit port IDs.
- Each edge with a non-empty queue: pop the head, raise that unit's grant bit for the port, and return the port to IDLE.
- Simultaneous arrivals into the same queue are enqueued in ascending port order (see Configuration).
- Pop and push in the same cycle are allowed; the count updates by net change.
- No bypass: an entry pushed at edge k cannot be popped before edge k+1.
- The two units arbitrate independently; one arith grant and one shift grant may be high in the same cycle.
- A port in IDLE during its grant cycle may strobe again; the new strobe is accepted normally.

## Timing
- Reset values: grant_arith=0, grant_shift=0, rej_vld=0, rej_code=0, arith_cnt=0, shift_cnt=0; all FSMs IDLE; queues empty.
- All outputs are registered.
- Strobe sampled at edge k:
  - reject visible in cycle k..k+1;
  - queue push at edge k;
  - earliest grant visible in cycle k+1..k+2.
- Minimum latency is 1 cycle from acceptance to grant. Queue position n adds n cycles.
- Reset asserted mid-operation flushes both queues, drops pending requests without grants, and forces all outputs to 0 within the same cycle.
- Deassertion of reset takes effect at the next rising edge.

## Configuration
- CALC1_ARB_ROTATE_EN undefined: simultaneous arrivals into one queue are enqueued lowest port first.
- CALC1_ARB_ROTATE_EN defined:
  - Simultaneous arrivals into one queue are enqueued starting from the port after the last port granted by that unit, wrapping 4→1.
  - The last-granted pointer for each unit resets to port 4, so port 1 goes first after reset.
- Arrival-order FIFO behaviour is identical in both builds.

## Structure
- calc1_pkg holds the shared definitions:
  - command constants: NOP=0, ADD=1, SUB=2, LSH=5, RSH=6;
  - response constants: NONE=0, SUCC=1, INOF=2, IERR=3;
  - port FSM state enum;
  - is_arith/is_shift classification functions.
- Sub-module calc1_port_fifo:
  - QDEPTH x 2-bit FIFO with multi-push (up to 4 ordered pushes per cycle), single pop and count output;
  - instantiated twice, once per unit.

## Test plan
- Port 1 strobes cmd 1 at edge 1 → grant_arith=0001 for one cycle after edge 2, arith_cnt 1 then 0.
- Ports 1–4 strobe cmd 2 at the same edge → grants in order ports 1,2,3,4 on four consecutive cycles, arith_cnt 4,3,2,1,0. With CALC1_ARB_ROTATE_EN defined and port 2 last granted, the order is 3,4,1,2.
- Port 3 strobes cmd 5 and port 4 strobes cmd 1 at the same edge → grant_shift=0100 and grant_arith=1000 in the same cycle.
- Port 2 strobes cmd 3 → rej_vld bit1=1 with rej_code=2 for one cycle; no queue push.
- Port 1 strobes cmd 1 while in WAIT_A → rej_code=3; its original grant still issues once.
- Three requests queued, reset pulled low mid-cycle → all outputs 0 immediately; counts 0; no grants after release.
